mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller servicing the MEM-stage load/store request interface and the IF-stage instruction fetch port.
- Drives a byte-wide synchronous RAM.
- Serialises each word, halfword or byte access into single-byte RAM cycles, assembles little-endian results, and returns a one-cycle completion pulse to the requester.
- Arbitrates between MEM and IF; MEM has priority.

Parameters:
ADDR_W, 32, width of byte addresses on all ports
DATA_W, 32, width of load/store/instruction data

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset; reset rst, synchronous, active-high
rdy  input  1  global enable; low = freeze
mem_addr_i  input  ADDR_W  MEM-stage byte address
load_or_not  input  1  MEM load request (level, held until mem_enable)
store_or_not  input  1  MEM store request (level, held until mem_enable)
num_of_bytes  input  3  access size: 3'b001, 3'b010, 3'b100
store_data  input  DATA_W  store value, low bytes used
load_data  output  DATA_W  assembled load value, zero-padded above num_of_bytes
mem_enable  output  1  one-cycle MEM completion pulse (load and store)
if_req  input  1  fetch request (level, held until if_done)
if_addr  input  ADDR_W  fetch byte address
if_inst  output  DATA_W  fetched instruction
if_done  output  1  one-cycle fetch completion pulse
ram_din  input  8  RAM read byte
ram_dout  output  8  RAM write byte
ram_a  output  ADDR_W  RAM byte address
ram_wr  output  1  RAM write strobe, 1 = write

Behaviour:
- RAM model:
  - The RAM samples ram_a, ram_wr and ram_dout at a rising edge.
  - Read data for that address is valid on ram_din during the following cycle.
- All outputs are registered, except ram_wr, which is gated with rdy.
- Reset (rst=1 at edge; overrides rdy):
  - State goes to IDLE; counters are cleared.
  - load_data, if_inst, ram_a, ram_dout = 0; mem_enable, if_done, ram_wr = 0.
  - Reset mid-access abandons it; a partially written store stays partially written; no completion pulse.
- rdy=0:
  - No state, counter or output register changes.
  - ram_wr is forced to 0.
  - A pending completion pulse is held until rdy returns, then lasts one cycle.
- States: IDLE, LOAD, STORE, FETCH, DONE.
- IDLE, at each edge:
  - Requests are checked in order: store_or_not, then load_or_not, then if_req.
  - The first one present is accepted; base address and size are latched and the byte counter is cleared.
- Illegal MEM requests:
  - Cases: num_of_bytes not in {1,2,4}, or load_or_not and store_or_not both high.
  - No RAM access occurs; go to DONE with load_data=0 and mem_enable pulsed.
- LOAD/FETCH, N bytes (FETCH always N=4):
  - ram_a = base+i is registered at accept edge E0+i, for i = 0..N-1; ram_wr stays 0.
  - Byte i is captured from ram_din at edge E(i+2).
  - At E(N+1): load_data (or if_inst) = {zero-pad, byte N-1, ..., byte 0}; mem_enable (or if_done) = 1; state goes to DONE.
  - Latency: LW and fetch pulse 5 edges after accept; LB pulses 2 edges after accept.
- STORE, N bytes:
  - At edge E(i), for i = 0..N-1: ram_a = base+i, ram_dout = store_data[8i+7:8i], ram_wr = 1.
  - At E(N): ram_wr = 0, mem_enable = 1, state goes to DONE.
- DONE:
  - Lasts one cycle; the pulse output clears and requests are ignored, which lets the requester drop its level request.
  - Then return to IDLE.
- load_data and if_inst hold their value until the next completion of the same kind.
- Address increment is modulo 2^ADDR_W: 0xFFFFFFFF+1 wraps to 0x00000000.
- A MEM request arriving during a FETCH waits; it is taken in the next IDLE, ahead of a still-pending if_req.

Test Plan:
- LW at 0x1000 with RAM bytes 0x1000..0x1003 = 78 56 34 12:
  - ram_a = 1000..1003 on consecutive cycles, ram_wr = 0.
  - mem_enable is high exactly one cycle, 5 edges after accept, with load_data = 0x12345678.
- SH at 0x2002, store_data = 0xDEADBEEF:
  - ram_wr = 1 for two cycles: (0x2002, 0xEF), then (0x2003, 0xBE).
  - mem_enable is pulsed 2 edges after accept; RAM bytes 0x2000, 0x2001 and 0x2004 are unchanged.
- LB at 0x3000 (RAM = 0x80), with if_req=1 asserted the same cycle:
  - load_data = 0x00000080; the MEM pulse comes first.
  - After DONE, the fetch starts and if_done follows with the correct if_inst.
- LW at 0xFFFFFFFE: ram_a sequence is FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rdy dropped for 3 cycles mid-SW:
  - ram_wr = 0 during the freeze; no byte is skipped or duplicated.
  - mem_enable timing shifts by exactly 3 cycles.
- rst asserted during FETCH byte 2:
  - Next cycle all outputs = 0 and state = IDLE; no if_done.
  - num_of_bytes = 3'b011 afterwards gives mem_enable next cycle, load_data = 0, and no RAM access.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: MEM load/store and IF fetch share one byte-wide synchronous RAM.
// MEM requests win arbitration; every access ends in a one-cycle DONE state.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              load_or_not,
  input  logic              store_or_not,
  input  logic [2:0]        num_of_bytes,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_enable,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned KW = $clog2(NB + 2) + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StStore, StFetch, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [2:0]        r_size, w_size_nxt;
  logic [KW-1:0]     r_k, w_k_nxt;
  logic [DATA_W-1:0] r_buf, w_buf_nxt;
  logic [DATA_W-1:0] r_sdata, w_sdata_nxt;
  logic [DATA_W-1:0] r_load_data, w_load_data_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic [DATA_W-1:0] r_if_inst, w_if_inst_nxt;
  logic              r_if_done, w_if_done_nxt;
  logic [ADDR_W-1:0] r_ram_a, w_ram_a_nxt;
  logic [7:0]        r_ram_dout, w_ram_dout_nxt;
  logic              r_wr, w_wr_nxt;

  logic              w_mem_req;
  logic              w_size_ok;
  logic              w_illegal;
  logic [DATA_W-1:0] w_buf_cap;

  assign w_mem_req = store_or_not | load_or_not;
  assign w_size_ok = (num_of_bytes == 3'd1) || (num_of_bytes == 3'd2) || (num_of_bytes == 3'd4);
  assign w_illegal = !w_size_ok || (store_or_not && load_or_not);

  // At edge k of a read, ram_din carries the byte addressed at edge k-2.
  always_comb begin
    w_buf_cap = r_buf;
    for (int b = 0; b < int'(NB); b++) begin
      if (int'(r_k) == b + 2) begin
        w_buf_cap[8*b +: 8] = ram_din;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_size_nxt      = r_size;
    w_k_nxt         = r_k;
    w_buf_nxt       = r_buf;
    w_sdata_nxt     = r_sdata;
    w_load_data_nxt = r_load_data;
    w_mem_en_nxt    = r_mem_en;
    w_if_inst_nxt   = r_if_inst;
    w_if_done_nxt   = r_if_done;
    w_ram_a_nxt     = r_ram_a;
    w_ram_dout_nxt  = r_ram_dout;
    w_wr_nxt        = r_wr;

    case (r_state)
      StIdle: begin
        w_k_nxt = KW'(1);
        if (w_mem_req) begin
          if (w_illegal) begin
            w_load_data_nxt = '0;
            w_mem_en_nxt    = 1'b1;
            w_state_nxt     = StDone;
          end else begin
            w_base_nxt  = mem_addr_i;
            w_size_nxt  = num_of_bytes;
            w_buf_nxt   = '0;
            w_sdata_nxt = store_data;
            w_ram_a_nxt = mem_addr_i;
            if (store_or_not) begin
              w_ram_dout_nxt = store_data[7:0];
              w_wr_nxt       = 1'b1;
              w_state_nxt    = StStore;
            end else begin
              w_state_nxt = StLoad;
            end
          end
        end else if (if_req) begin
          w_base_nxt  = if_addr;
          w_size_nxt  = 3'd4;
          w_buf_nxt   = '0;
          w_ram_a_nxt = if_addr;
          w_state_nxt = StFetch;
        end
      end

      StLoad, StFetch: begin
        w_k_nxt   = r_k + KW'(1);
        w_buf_nxt = w_buf_cap;
        if (int'(r_k) < int'(r_size)) begin
          w_ram_a_nxt = r_base + ADDR_W'(r_k);
        end
        if (int'(r_k) == int'(r_size) + 1) begin
          if (r_state == StLoad) begin
            w_load_data_nxt = w_buf_cap;
            w_mem_en_nxt    = 1'b1;
          end else begin
            w_if_inst_nxt = w_buf_cap;
            w_if_done_nxt = 1'b1;
          end
          w_state_nxt = StDone;
        end
      end

      StStore: begin
        w_k_nxt = r_k + KW'(1);
        if (int'(r_k) < int'(r_size)) begin
          w_ram_a_nxt    = r_base + ADDR_W'(r_k);
          w_ram_dout_nxt = r_sdata[{r_k, 3'b000} +: 8];
          w_wr_nxt       = 1'b1;
        end else begin
          w_wr_nxt     = 1'b0;
          w_mem_en_nxt = 1'b1;
          w_state_nxt  = StDone;
        end
      end

      // Requests are ignored here so the requester can drop its level request.
      StDone: begin
        w_mem_en_nxt  = 1'b0;
        w_if_done_nxt = 1'b0;
        w_state_nxt   = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_size      <= '0;
      r_k         <= '0;
      r_buf       <= '0;
      r_sdata     <= '0;
      r_load_data <= '0;
      r_mem_en    <= 1'b0;
      r_if_inst   <= '0;
      r_if_done   <= 1'b0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_wr        <= 1'b0;
    end else if (rdy) begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_size      <= w_size_nxt;
      r_k         <= w_k_nxt;
      r_buf       <= w_buf_nxt;
      r_sdata     <= w_sdata_nxt;
      r_load_data <= w_load_data_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_done   <= w_if_done_nxt;
      r_ram_a     <= w_ram_a_nxt;
      r_ram_dout  <= w_ram_dout_nxt;
      r_wr        <= w_wr_nxt;
    end
  end

  assign load_data  = r_load_data;
  assign mem_enable = r_mem_en;
  assign if_inst    = r_if_inst;
  assign if_done    = r_if_done;
  assign ram_a      = r_ram_a;
  assign ram_dout   = r_ram_dout;
  // A frozen controller must never write, even with a store mid-flight.
  assign ram_wr     = r_wr & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM, transaction-schedule reference model, per-cycle compare
// and directed scenarios with literal expectations.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_addr_i;
  logic        load_or_not;
  logic        store_or_not;
  logic [2:0]  num_of_bytes;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        mem_enable;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .mem_addr_i   (mem_addr_i),
    .load_or_not  (load_or_not),
    .store_or_not (store_or_not),
    .num_of_bytes (num_of_bytes),
    .store_data   (store_data),
    .load_data    (load_data),
    .mem_enable   (mem_enable),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_inst      (if_inst),
    .if_done      (if_done),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .ram_a        (ram_a),
    .ram_wr       (ram_wr)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM seen by the DUT (low 16 address bits decode; test addresses do not alias).
  logic [7:0] ram_mem [0:65535];
  logic [7:0] rd_byte;
  initial forever begin
    @(posedge clk);
    rd_byte = ram_mem[ram_a[15:0]];
    if (ram_wr) ram_mem[ram_a[15:0]] = ram_dout;
    ram_din <= rd_byte;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance, schedule the whole transaction on an active-edge timeline.
  logic [7:0]  mdl_mem [0:65535];
  logic [31:0] exp_a [int];
  logic [7:0]  exp_dout [int];
  bit          exp_wr [int];
  bit          mem_pulse [int];
  logic [31:0] ld_val [int];
  bit          if_pulse [int];
  logic [31:0] if_val [int];
  int          n = 0;
  int          free_at = 0;
  int          nb;
  bit          mdl_valid = 1'b0;
  logic [31:0] ma, mv;
  logic [31:0] m_ld, m_if, m_a;
  logic [7:0]  m_dout;
  bit          m_wr, m_men, m_ifd;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mdl_valid = 1'b1;
      exp_a.delete(); exp_dout.delete(); exp_wr.delete(); mem_pulse.delete();
      ld_val.delete(); if_pulse.delete(); if_val.delete();
      m_ld = '0; m_if = '0; m_a = '0; m_dout = '0; m_wr = 0; m_men = 0; m_ifd = 0;
      free_at = n + 1;
    end else if (rdy) begin
      n++;
      if (n >= free_at) begin
        nb = int'(num_of_bytes);
        if (store_or_not || load_or_not) begin
          if ((store_or_not && load_or_not) || !(nb == 1 || nb == 2 || nb == 4)) begin
            mem_pulse[n] = 1'b1;
            ld_val[n]    = '0;
            free_at      = n + 2;
          end else if (store_or_not) begin
            for (int i = 0; i < nb; i++) begin
              ma              = mem_addr_i + 32'(i);
              exp_a[n+i]      = ma;
              exp_dout[n+i]   = store_data[8*i +: 8];
              exp_wr[n+i]     = 1'b1;
              mdl_mem[ma[15:0]] = store_data[8*i +: 8];
            end
            mem_pulse[n+nb] = 1'b1;
            free_at         = n + nb + 2;
          end else begin
            mv = '0;
            for (int i = 0; i < nb; i++) begin
              ma            = mem_addr_i + 32'(i);
              exp_a[n+i]    = ma;
              mv[8*i +: 8]  = mdl_mem[ma[15:0]];
            end
            mem_pulse[n+nb+1] = 1'b1;
            ld_val[n+nb+1]    = mv;
            free_at           = n + nb + 3;
          end
        end else if (if_req) begin
          mv = '0;
          for (int i = 0; i < 4; i++) begin
            ma           = if_addr + 32'(i);
            exp_a[n+i]   = ma;
            mv[8*i +: 8] = mdl_mem[ma[15:0]];
          end
          if_pulse[n+5] = 1'b1;
          if_val[n+5]   = mv;
          free_at       = n + 7;
        end
      end
      if (exp_a.exists(n)) m_a = exp_a[n];
      if (exp_dout.exists(n)) m_dout = exp_dout[n];
      m_wr  = exp_wr.exists(n);
      m_men = mem_pulse.exists(n);
      if (ld_val.exists(n)) m_ld = ld_val[n];
      m_ifd = if_pulse.exists(n);
      if (if_val.exists(n)) m_if = if_val[n];
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (mdl_valid) begin
      chk("load_data", load_data, m_ld);
      chk("mem_enable", 32'(mem_enable), 32'(m_men));
      chk("if_inst", if_inst, m_if);
      chk("if_done", 32'(if_done), 32'(m_ifd));
      chk("ram_a", ram_a, m_a);
      chk("ram_dout", 32'(ram_dout), 32'(m_dout));
      chk("ram_wr", 32'(ram_wr), 32'(m_wr & rdy));
    end
  end

  task automatic setb(input logic [31:0] a, input logic [7:0] v);
    ram_mem[a[15:0]] = v;
    mdl_mem[a[15:0]] = v;
  endtask

  // Caller sits at a negedge; returns the number of rising edges until the pulse is seen.
  task automatic mem_req(input logic st, input logic ld, input logic [31:0] a,
                         input logic [2:0] nbytes, input logic [31:0] d, output int lat);
    int start;
    start        = cyc;
    store_or_not = st;
    load_or_not  = ld;
    mem_addr_i   = a;
    num_of_bytes = nbytes;
    store_data   = d;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (mem_enable) break;
    end
    lat = cyc - start;
    if (!mem_enable) begin
      checks++;
      errors++;
      $display("FAIL mem_enable_timeout: got 0 expected 1 at %0t", $time);
    end
    store_or_not = 1'b0;
    load_or_not  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_if(input int start, output int lat);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (if_done) break;
    end
    lat = cyc - start;
    if (!if_done) begin
      checks++;
      errors++;
      $display("FAIL if_done_timeout: got 0 expected 1 at %0t", $time);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int lat;
  int if_start;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'h00;
      mdl_mem[i] = 8'h00;
    end
    setb(32'h1000, 8'h78); setb(32'h1001, 8'h56); setb(32'h1002, 8'h34); setb(32'h1003, 8'h12);
    setb(32'h2000, 8'h11); setb(32'h2001, 8'h22); setb(32'h2002, 8'h33); setb(32'h2003, 8'h44);
    setb(32'h2004, 8'h55);
    setb(32'h3000, 8'h80);
    setb(32'h4000, 8'h93); setb(32'h4001, 8'h00); setb(32'h4002, 8'h10); setb(32'h4003, 8'h00);
    setb(32'hFFFFFFFE, 8'hAA); setb(32'hFFFFFFFF, 8'hBB);
    setb(32'h00000000, 8'hCC); setb(32'h00000001, 8'hDD);
    setb(32'h5000, 8'h01); setb(32'h5001, 8'h02); setb(32'h5002, 8'h03); setb(32'h5003, 8'h04);

    rst = 1'b1; rdy = 1'b1;
    mem_addr_i = '0; load_or_not = 0; store_or_not = 0; num_of_bytes = 3'd0; store_data = '0;
    if_req = 0; if_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Word load.
    mem_req(1'b0, 1'b1, 32'h1000, 3'b100, 32'h0, lat);
    chk("lw_latency", 32'(lat), 32'd6);
    chk("lw_value", load_data, 32'h12345678);

    // Load and store both high: illegal, no RAM access.
    mem_req(1'b1, 1'b1, 32'h1000, 3'b100, 32'hFFFFFFFF, lat);
    chk("both_latency", 32'(lat), 32'd1);
    chk("both_value", load_data, 32'h0);
    chk("both_ram_untouched", 32'(ram_mem[16'h1000]), 32'h78);

    // Halfword store at 0x2002.
    mem_req(1'b1, 1'b0, 32'h2002, 3'b010, 32'hDEADBEEF, lat);
    chk("sh_latency", 32'(lat), 32'd3);
    chk("sh_2000", 32'(ram_mem[16'h2000]), 32'h11);
    chk("sh_2001", 32'(ram_mem[16'h2001]), 32'h22);
    chk("sh_2002", 32'(ram_mem[16'h2002]), 32'hEF);
    chk("sh_2003", 32'(ram_mem[16'h2003]), 32'hBE);
    chk("sh_2004", 32'(ram_mem[16'h2004]), 32'h55);

    // Byte load with a fetch raised in the same cycle.
    if_addr  = 32'h4000;
    if_req   = 1'b1;
    if_start = cyc;
    mem_req(1'b0, 1'b1, 32'h3000, 3'b001, 32'h0, lat);
    chk("lb_latency", 32'(lat), 32'd3);
    chk("lb_value", load_data, 32'h00000080);
    wait_if(if_start, lat);
    chk("fetch_latency", 32'(lat), 32'd10);
    chk("fetch_value", if_inst, 32'h00100093);

    // Word load across the address wrap.
    mem_req(1'b0, 1'b1, 32'hFFFFFFFE, 3'b100, 32'h0, lat);
    chk("wrap_latency", 32'(lat), 32'd6);
    chk("wrap_value", load_data, 32'hDDCCBBAA);

    // Word store with a three-cycle freeze in the middle.
    fork
      mem_req(1'b1, 1'b0, 32'h6000, 3'b100, 32'hCAFEF00D, lat);
      begin
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
      end
    join
    chk("sw_freeze_latency", 32'(lat), 32'd8);
    chk("sw_6000", 32'(ram_mem[16'h6000]), 32'h0D);
    chk("sw_6001", 32'(ram_mem[16'h6001]), 32'hF0);
    chk("sw_6002", 32'(ram_mem[16'h6002]), 32'hFE);
    chk("sw_6003", 32'(ram_mem[16'h6003]), 32'hCA);
    mem_req(1'b0, 1'b1, 32'h6000, 3'b100, 32'h0, lat);
    chk("sw_readback", load_data, 32'hCAFEF00D);

    // Reset in the middle of a fetch.
    if_addr = 32'h5000;
    if_req  = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_flags", {29'd0, mem_enable, if_done, ram_wr}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_if_done", 32'(if_done), 32'h0);

    // Illegal size after reset.
    mem_req(1'b0, 1'b1, 32'h1000, 3'b011, 32'h0, lat);
    chk("bad_size_latency", 32'(lat), 32'd1);
    chk("bad_size_value", load_data, 32'h0);
    chk("bad_size_no_access", ram_a, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
